// File: rtl/n4fpga_pwm_duty_calc.sv
// PWM duty calculator: duty = floor(high*SCALE / (high+low)), computed by a
// 40-cycle restoring divider so no wide combinational divider is needed.
module n4fpga_pwm_duty_calc #(
  parameter int unsigned SCALE = 100
) (
  input  logic        clock_3,
  input  logic        Reset,
  input  logic [31:0] high_count,
  input  logic [31:0] low_count,
  input  logic        start,
  output logic [7:0]  duty,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, DONE} state_t;

  localparam logic [7:0] SCALE_W  = 8'(SCALE);
  localparam logic [5:0] LAST_ITER = 6'd39;

  state_t      state, state_nxt;
  logic [31:0] high_q, low_q;
  logic [32:0] period_q;
  logic [39:0] num_q;
  logic [39:0] quot_q;
  logic [33:0] rem_q;
  logic [5:0]  iter_q;

  logic [32:0] period_sum;
  logic [39:0] num_prod;
  logic [34:0] step_w;
  logic [39:0] quot_nxt;

  // One restoring-division step: returns {quotient_bit, new_remainder}.
  function automatic logic [34:0] div_step(input logic [33:0] rem,
                                           input logic        nbit,
                                           input logic [32:0] divisor);
    logic [34:0] trial;
    trial = {rem, nbit};
    if (trial >= {2'b00, divisor})
      div_step = {1'b1, 34'(trial - {2'b00, divisor})};
    else
      div_step = {1'b0, trial[33:0]};
  endfunction

  // Quotient never exceeds SCALE, so this clamp is only a guard.
  function automatic logic [7:0] sat_u8(input logic [39:0] q);
    sat_u8 = (|q[39:8]) ? 8'hFF : q[7:0];
  endfunction

  assign period_sum = {1'b0, high_q} + {1'b0, low_q};
  assign num_prod   = {8'd0, high_q} * {32'd0, SCALE_W};
  assign step_w     = div_step(rem_q, num_q[39], period_q);
  assign quot_nxt   = {quot_q[38:0], step_w[34]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock_3) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (period_sum == '0) ? DONE : DIVIDE;
      DIVIDE:  if (iter_q == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // duty/err are written on the edge entering DONE so they are valid with done.
  always_ff @(posedge clock_3) begin
    if (Reset) begin
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      num_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      iter_q   <= '0;
      duty     <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            high_q <= high_count;
            low_q  <= low_count;
          end
        end
        LOAD: begin
          period_q <= period_sum;
          num_q    <= num_prod;
          quot_q   <= '0;
          rem_q    <= '0;
          iter_q   <= '0;
          if (period_sum == '0) begin
            duty <= '0;
            err  <= 1'b1;
          end
        end
        DIVIDE: begin
          rem_q  <= step_w[33:0];
          quot_q <= quot_nxt;
          num_q  <= {num_q[38:0], 1'b0};
          iter_q <= iter_q + 6'd1;
          if (iter_q == LAST_ITER) begin
            duty <= sat_u8(quot_nxt);
            err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_n4fpga_pwm_duty_calc.sv
// Scoreboard bench for n4fpga_pwm_duty_calc: driver pushes expected results,
// negedge monitor pops on done and checks hold/busy behaviour every cycle.
module tb_n4fpga_pwm_duty_calc;

  localparam int unsigned SCALE = 100;

  logic        clock_3 = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] high_count = '0;
  logic [31:0] low_count = '0;
  logic [7:0]  duty;
  logic        busy;
  logic        done;
  logic        err;

  n4fpga_pwm_duty_calc #(.SCALE(SCALE)) dut (
    .clock_3(clock_3),
    .Reset(Reset),
    .high_count(high_count),
    .low_count(low_count),
    .start(start),
    .duty(duty),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clock_3 = ~clock_3;

  typedef struct {
    int       due;
    logic [7:0] duty;
    logic     err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         free_at = 0;
  int         busy_from = 0;
  logic [7:0] mdl_duty = '0;
  logic       mdl_err = 1'b0;
  bit         mon_en = 1'b0;

  always @(posedge clock_3) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference: the duty ratio in plain integer arithmetic plus the fixed latency.
  function automatic exp_t model(input int c, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    longint unsigned hh, per;
    hh  = {32'd0, h};
    per = hh + {32'd0, l};
    if (per == 0) begin
      e.due  = c + 2;
      e.duty = 8'd0;
      e.err  = 1'b1;
    end else begin
      e.due  = c + 42;
      e.duty = 8'((hh * SCALE) / per);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic drive(input bit s, input logic [31:0] h, input logic [31:0] l, input bit r);
    exp_t e;
    @(posedge clock_3);
    #1;
    Reset      = r;
    start      = s;
    high_count = h;
    low_count  = l;
    if (r) begin
      if (free_at > cyc + 1) free_at = cyc + 1;
    end else if (s && cyc >= free_at) begin
      e = model(cyc, h, l);
      sb.push_back(e);
      busy_from = cyc + 1;
      free_at   = e.due + 1;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic wait_idle();
    while (free_at > cyc + 1) drive(1'b0, 32'($urandom), 32'($urandom), 1'b0);
  endtask

  task automatic one_req(input logic [31:0] h, input logic [31:0] l);
    wait_idle();
    drive(1'b1, h, l, 1'b0);
  endtask

  always @(negedge clock_3) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", {63'd0, done}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.due));
          chk("duty", {56'd0, duty}, {56'd0, mon_e.duty});
          chk("err", {63'd0, err}, {63'd0, mon_e.err});
          mdl_duty = mon_e.duty;
          mdl_err  = mon_e.err;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missed_done", {63'd0, done}, 64'd1);
        void'(sb.pop_front());
      end
      chk("duty_hold", {56'd0, duty}, {56'd0, mdl_duty});
      chk("err_hold", {63'd0, err}, {63'd0, mdl_err});
      chk("busy", {63'd0, busy}, {63'd0, (cyc >= busy_from && cyc < free_at)});
      if (Reset) begin
        sb.delete();
        mdl_duty = '0;
        mdl_err  = 1'b0;
      end
    end
  end

  initial begin
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    drive(1'b1, 32'd5, 32'd5, 1'b1);
    mon_en = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    chk("rst_duty", {56'd0, duty}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);

    one_req(32'd25, 32'd75);
    one_req(32'd1, 32'd2);
    one_req(32'd2, 32'd1);
    one_req(32'd0, 32'd0);
    one_req(32'd10, 32'd0);
    one_req(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    one_req(32'hFFFF_FFFF, 32'd0);
    one_req(32'd0, 32'd7);

    // start held for 60 cycles with changing operands
    wait_idle();
    repeat (60) drive(1'b1, rnd_op(), rnd_op(), 1'b0);

    // reset in cycle 20 of a computation, restart two cycles later
    wait_idle();
    drive(1'b1, 32'd30, 32'd70, 1'b0);
    repeat (19) drive(1'b0, 32'($urandom), 32'($urandom), 1'b0);
    drive(1'b1, 32'd3, 32'd4, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    chk("rst_mid_duty", {56'd0, duty}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    drive(1'b1, 32'd40, 32'd60, 1'b0);

    repeat (1500)
      drive($urandom_range(0, 7) == 0, rnd_op(), rnd_op(), $urandom_range(0, 299) == 0);

    for (int i = 0; i < 100 && sb.size() > 0; i++)
      drive(1'b0, 32'd0, 32'd0, 1'b0);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
